// File: rtl/router_pkg.sv
// router_pkg: shared widths, tx state encoding and header helpers for the router packet path
package router_pkg;
  localparam int ADDR_W = 2;
  localparam int LEN_W = 6;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;
  typedef enum logic [2:0] {IDLE, LOAD, HDR, PLD, PAR, GAP} tx_state_t;
  function automatic logic [DATA_W-1:0] pack_hdr(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    return {len, addr};
  endfunction
  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
    return hdr[ADDR_W-1:0];
  endfunction
  function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return hdr[DATA_W-1:ADDR_W];
  endfunction
endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf: payload store, synchronous write, combinational read, no reset on the array
module router_tx_buf #(
  parameter int DEPTH = 63,
  parameter int W = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  // write one payload byte per accepted beat
  always_ff @(posedge clk)
    if (we && int'(waddr) < DEPTH) mem[waddr] <= wdata;
  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;
endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a full payload then drives header, payload, parity into the router; ROUTER_TX_PARITY_INJECT_EN adds inj_err
module router_pkt_tx import router_pkg::*; #(
  parameter int MAX_LEN = 63,
  parameter int IFG = 3
) (
  input  logic              router_clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              pld_valid,
  input  logic [DATA_W-1:0] pld_data,
  output logic              pld_ready,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_in,
  output logic              tx_done,
`ifdef ROUTER_TX_PARITY_INJECT_EN
  input  logic              inj_err,
`endif
  output logic              cmd_err
);
  localparam int GW = $clog2(IFG + 1);
  tx_state_t state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] len, wr_ptr, rd_ptr, rd_addr;
  logic [DATA_W-1:0] parity, rd_data;
  logic [GW-1:0] gap_cnt;
  logic cmd_acc, cmd_bad, inj;
  assign cmd_acc = cmd_valid && cmd_ready && state == IDLE;
  assign cmd_bad = (cmd_addr == INVALID_ADDR) || (cmd_len == '0) || (int'(cmd_len) > MAX_LEN);
  // the byte needed next: payload[0] while the header is out, otherwise the one after the current
  assign rd_addr = (state == HDR) ? '0 : rd_ptr + LEN_W'(1);
  router_tx_buf #(.DEPTH(MAX_LEN), .W(DATA_W), .AW(LEN_W)) u_buf (
    .clk(router_clock),
    .we(pld_valid && pld_ready),
    .waddr(wr_ptr),
    .wdata(pld_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
`ifdef ROUTER_TX_PARITY_INJECT_EN
  // remember the injection request with the command it came with
  always_ff @(posedge router_clock or negedge resetn)
    if (!resetn) inj <= 1'b0;
    else if (cmd_acc) inj <= inj_err;
`else
  assign inj = 1'b0;
`endif
  // packet sequencer, all outputs registered; busy only stalls HDR/PLD/PAR
  always_ff @(posedge router_clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      addr <= '0;
      len <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      parity <= '0;
      gap_cnt <= '0;
      cmd_ready <= 1'b0;
      pld_ready <= 1'b0;
      pkt_valid <= 1'b0;
      data_in <= '0;
      tx_done <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_acc) begin
            if (cmd_bad) cmd_err <= 1'b1;
            else begin
              addr <= cmd_addr;
              len <= cmd_len;
              wr_ptr <= '0;
              cmd_ready <= 1'b0;
              pld_ready <= 1'b1;
              state <= LOAD;
            end
          end
        end
        LOAD:
          if (pld_valid && pld_ready) begin
            if (wr_ptr == len - LEN_W'(1)) begin
              pld_ready <= 1'b0;
              pkt_valid <= 1'b1;
              data_in <= pack_hdr(addr, len);
              parity <= pack_hdr(addr, len);
              state <= HDR;
            end else wr_ptr <= wr_ptr + LEN_W'(1);
          end
        HDR:
          if (!busy) begin
            data_in <= rd_data;
            rd_ptr <= '0;
            state <= PLD;
          end
        PLD:
          if (!busy) begin
            parity <= parity ^ data_in;
            if (rd_ptr == len - LEN_W'(1)) begin
              pkt_valid <= 1'b0;
              data_in <= parity ^ data_in ^ {DATA_W{inj}};
              state <= PAR;
            end else begin
              rd_ptr <= rd_ptr + LEN_W'(1);
              data_in <= rd_data;
            end
          end
        PAR:
          if (!busy) begin
            tx_done <= 1'b1;
            data_in <= '0;
            gap_cnt <= '0;
            state <= GAP;
          end
        GAP:
          if (gap_cnt == GW'(IFG - 1)) begin
            cmd_ready <= 1'b1;
            state <= IDLE;
          end else gap_cnt <= gap_cnt + GW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed and randomized checks of router_pkt_tx against a byte-stream reference model
module tb_router_pkt_tx;
  localparam int IFG = 3;
  logic router_clock = 1'b0;
  logic resetn = 1'b0;
  logic cmd_valid = 1'b0, pld_valid = 1'b0, busy = 1'b0, inj_err = 1'b0;
  logic [1:0] cmd_addr = '0;
  logic [5:0] cmd_len = '0;
  logic [7:0] pld_data = '0;
  logic cmd_ready, pld_ready, pkt_valid, tx_done, cmd_err;
  logic [7:0] data_in;
  int n_tests = 0, n_fail = 0;
  logic [7:0] pl [64];
  logic [7:0] exp_b [$];
  logic exp_pv [$];
  bit rand_busy = 0;
  bit after_pv = 0, prev_pv = 0, prev_busy = 0, exp_done = 0, gap_on = 0;
  logic [7:0] prev_d = '0, eb;
  logic ep;
  int gap_cnt = 0, xfers = 0;

  router_pkt_tx #(.MAX_LEN(63), .IFG(IFG)) dut (
    .router_clock(router_clock),
    .resetn(resetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .pld_valid(pld_valid),
    .pld_data(pld_data),
    .pld_ready(pld_ready),
    .busy(busy),
    .pkt_valid(pkt_valid),
    .data_in(data_in),
    .tx_done(tx_done),
`ifdef ROUTER_TX_PARITY_INJECT_EN
    .inj_err(inj_err),
`endif
    .cmd_err(cmd_err)
  );

  always #5 router_clock = ~router_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // protocol monitor: every byte that transfers must be the next one the model expects
  always @(negedge router_clock) begin
    if (!resetn) begin
      after_pv = 0; prev_pv = 0; prev_busy = 0; exp_done = 0; gap_on = 0;
    end else begin
      if (gap_on) begin
        if (cmd_ready) begin check("ifg", gap_cnt, IFG); gap_on = 0; end
        else gap_cnt++;
      end
      if (exp_done || tx_done) check("tx_done", tx_done, exp_done);
      exp_done = 0;
      if (prev_pv && prev_busy) begin
        check("hold_pv", pkt_valid, 1);
        check("hold_d", data_in, prev_d);
      end
      if (!busy && (pkt_valid || after_pv)) begin
        xfers++;
        if (exp_b.size() == 0) check("unexpected", exp_b.size(), 1);
        else begin
          eb = exp_b.pop_front();
          ep = exp_pv.pop_front();
          check(ep ? "byte" : "parity", data_in, eb);
          check("pv", pkt_valid, ep);
        end
        if (!pkt_valid) begin after_pv = 0; exp_done = 1; gap_on = 1; gap_cnt = 0; end
        else after_pv = 1;
      end
      prev_pv = pkt_valid; prev_busy = busy; prev_d = data_in;
    end
  end

  initial forever begin
    @(posedge router_clock); #1;
    if (rand_busy) busy = ($urandom_range(0, 2) == 0);
  end

  task automatic step();
    @(posedge router_clock); #1;
  endtask

  // offer a command with payload pl[0..l-1]; valid commands also feed the model
  task automatic load_pkt(input logic [1:0] a, input logic [5:0] l, input logic inj);
    int t;
    logic [7:0] par;
    t = 0;
    while (!cmd_ready && t < 200) begin step(); t++; end
    if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_addr = a; cmd_len = l; inj_err = inj;
    step();
    cmd_valid = 0;
    if (a == 2'd3 || l == 0) begin
      check("cmd_err", cmd_err, 1);
      check("pld_ready_bad", pld_ready, 0);
      return;
    end
    par = {l, a};
    exp_b.push_back(par); exp_pv.push_back(1);
    for (int i = 0; i < l; i++) begin
      exp_b.push_back(pl[i]); exp_pv.push_back(1);
      par ^= pl[i];
    end
`ifdef ROUTER_TX_PARITY_INJECT_EN
    if (inj) par = ~par;
`endif
    exp_b.push_back(par); exp_pv.push_back(0);
    for (int i = 0; i < l; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        pld_valid = 0; pld_data = 8'($urandom); step();
      end
      pld_valid = 1; pld_data = pl[i];
      t = 0;
      while (!pld_ready && t < 100) begin step(); t++; end
      if (!pld_ready) check("pld_ready_wait", pld_ready, 1);
      step();
    end
    pld_valid = 0;
    check("pld_ready_drop", pld_ready, 0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_b.size() != 0 && t < 2000) begin step(); t++; end
    if (exp_b.size() != 0) check("drain", exp_b.size(), 0);
  endtask

  initial begin
    int t, x0;
    logic [1:0] a;
    logic [5:0] l;
    logic inj;
    #2;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_pld_ready", pld_ready, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_data_in", data_in, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_cmd_err", cmd_err, 0);
    #10 resetn = 1;
    step();
    check("idle_cmd_ready", cmd_ready, 1);

    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    load_pkt(2'd1, 6'd3, 0);
    wait_done();

    load_pkt(2'd1, 6'd3, 0);
    t = 0;
    while (!(pkt_valid && data_in == 8'h11) && t < 50) begin step(); t++; end
    check("see_11", data_in, 8'h11);
    step();
    busy = 1;
    repeat (4) step();
    check("hold22_pv", pkt_valid, 1);
    check("hold22", data_in, 8'h22);
    busy = 0;
    wait_done();

    load_pkt(2'd3, 6'd5, 0);
    load_pkt(2'd1, 6'd0, 0);
    repeat (5) step();
    check("bad_pkt_valid", pkt_valid, 0);
    check("bad_pld_ready", pld_ready, 0);
    check("bad_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 63; i++) pl[i] = 8'(i);
    x0 = xfers;
    load_pkt(2'd2, 6'd63, 0);
    wait_done();
    check("xfers63", xfers - x0, 65);

    for (int i = 0; i < 20; i++) pl[i] = 8'($urandom);
    x0 = xfers;
    load_pkt(2'd0, 6'd20, 0);
    t = 0;
    while (xfers - x0 < 11 && t < 100) begin step(); t++; end
    check("abort_reach", xfers - x0, 11);
    #2 resetn = 0;
    #1;
    check("abort_pkt_valid", pkt_valid, 0);
    check("abort_data_in", data_in, 0);
    check("abort_cmd_ready", cmd_ready, 0);
    exp_b.delete(); exp_pv.delete();
    step();
    resetn = 1;
    step();
    for (int i = 0; i < 7; i++) pl[i] = 8'($urandom);
    load_pkt(2'd2, 6'd7, 0);
    wait_done();

`ifdef ROUTER_TX_PARITY_INJECT_EN
    pl[0] = 8'hAA;
    load_pkt(2'd0, 6'd1, 1);
    wait_done();
`endif

    rand_busy = 1;
    for (int k = 0; k < 30; k++) begin
      a = 2'($urandom_range(0, 3));
      l = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      inj = 1'($urandom_range(0, 1));
      for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
      load_pkt(a, l, inj);
      wait_done();
    end
    rand_busy = 0;
    busy = 0;
    repeat (8) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
